// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one registered bus master between the core data port and the debug port.
// Latency: grant on the edge after a request in IDLE; completion is combinational on bus_ack or timeout.
// Backpressure: requesters hold request and payload until ack; a stalled slave is cut off after TIMEOUT_CYCLES.
// Ports: clk/reset; core mem_* load/store request, mem_rdata_mem/mem_ack_mem response, stall_pipl;
//        debug dbg_* request, dbg_rdata/dbg_ack/dbg_err response; bus_* registered master outputs,
//        bus_rdata/bus_ack slave response.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_mem,
  input  logic        mem_write_mem,
  input  logic [31:0] mem_addr_mem,
  input  logic [31:0] mem_wdata_mem,
  input  logic [2:0]  mem_op_mem,
  output logic [31:0] mem_rdata_mem,
  output logic        mem_ack_mem,
  output logic        stall_pipl,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic [2:0]  dbg_op,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ack,
  output logic        dbg_err,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [2:0]  bus_op,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  // Counter only has to reach TIMEOUT_CYCLES-1; never narrower than 8 bits.
  localparam int CW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GNT_CORE, GNT_DBG} state_t;
  typedef enum logic {LAST_CORE, LAST_DBG} owner_t;

  state_t        state, state_nxt;
  owner_t        last_grant;
  logic [CW-1:0] cnt;
  logic          core_req;
  logic          grant_core, grant_dbg;
  logic          done, timeout;
  logic          cyc_q;

  assign core_req = mem_read_mem | mem_write_mem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant_core = 1'b0;
    grant_dbg  = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the port that did not win last time goes first.
        if (core_req && (!dbg_req || last_grant == LAST_DBG)) begin
          grant_core = 1'b1;
          state_nxt  = GNT_CORE;
        end else if (dbg_req) begin
          grant_dbg = 1'b1;
          state_nxt = GNT_DBG;
        end
      end
      GNT_CORE, GNT_DBG: begin
        // A slave ack on the final allowed cycle wins over the timeout.
        if (bus_ack) begin
          done = 1'b1;
        end else if (cnt == CNT_LAST) begin
          done    = 1'b1;
          timeout = 1'b1;
        end
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= LAST_DBG;
      cnt        <= '0;
      cyc_q      <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_op     <= '0;
    end else begin
      if (grant_core || grant_dbg) begin
        cnt   <= '0;
        cyc_q <= 1'b1;
      end else if (done) begin
        cyc_q <= 1'b0;
      end else if (state != IDLE) begin
        cnt <= cnt + CW'(1);
      end

      // Payload is captured only at grant and held for the whole bus cycle.
      if (grant_core) begin
        last_grant <= LAST_CORE;
        bus_we     <= mem_write_mem;
        bus_addr   <= mem_addr_mem;
        bus_wdata  <= mem_wdata_mem;
        bus_op     <= mem_op_mem;
      end else if (grant_dbg) begin
        last_grant <= LAST_DBG;
        bus_we     <= dbg_we;
        bus_addr   <= dbg_addr;
        bus_wdata  <= dbg_wdata;
        bus_op     <= dbg_op;
      end
    end
  end

  assign bus_cyc = cyc_q;
  assign bus_stb = cyc_q;

  // Read data reaches only the owner, and only on a real slave ack (timeout returns zero).
  assign mem_ack_mem   = done && (state == GNT_CORE);
  assign mem_rdata_mem = (state == GNT_CORE && bus_ack) ? bus_rdata : 32'h0;
  assign dbg_ack       = done && (state == GNT_DBG);
  assign dbg_err       = timeout && (state == GNT_DBG);
  assign dbg_rdata     = (state == GNT_DBG && bus_ack) ? bus_rdata : 32'h0;

  assign stall_pipl = core_req & ~mem_ack_mem;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios with literal expectations, then randomized
// traffic against a transaction-level reference model compared on every falling clock edge.
module tb_mem_bus_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_mem, mem_write_mem;
  logic [31:0] mem_addr_mem, mem_wdata_mem;
  logic [2:0]  mem_op_mem;
  logic [31:0] mem_rdata_mem;
  logic        mem_ack_mem, stall_pipl;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic [2:0]  dbg_op;
  logic [31:0] dbg_rdata;
  logic        dbg_ack, dbg_err;
  logic        bus_cyc, bus_stb, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [2:0]  bus_op;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
    .mem_addr_mem(mem_addr_mem), .mem_wdata_mem(mem_wdata_mem), .mem_op_mem(mem_op_mem),
    .mem_rdata_mem(mem_rdata_mem), .mem_ack_mem(mem_ack_mem), .stall_pipl(stall_pipl),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_op(dbg_op),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_op(bus_op),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- slave model ----------------
  int          slv_mode = 1;        // 0: random latency per transfer, 1: fixed
  int          slv_lat = 0;         // fixed mode: ack on this bus cycle of the transfer, 0 = never
  bit          slv_idle_ack = 1'b0; // fixed mode: drive ack while the bus is idle
  logic [31:0] slv_data = 32'hCAFEF00D;
  int          scnt = 0;
  int          cur_lat = 0;

  always @(posedge clk) begin
    #1;
    if (bus_cyc === 1'b1) scnt++;
    else scnt = 0;
    if (scnt == 1) cur_lat = (slv_mode == 0) ? int'($urandom_range(1, TO + 2)) : slv_lat;
    if (scnt != 0 && cur_lat != 0 && scnt == cur_lat) begin
      bus_ack   = 1'b1;
      bus_rdata = (slv_mode == 0) ? $urandom : slv_data;
    end else if (scnt == 0 && (slv_idle_ack || (slv_mode == 0 && $urandom_range(0, 3) == 0))) begin
      bus_ack   = 1'b1;
      bus_rdata = $urandom;
    end else begin
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
    end
  end

  // ---------------- reference model ----------------
  int          m_owner;  // 0 none, 1 core, 2 debug
  int          m_prev;   // last port granted: 1 core, 2 debug
  int          m_gcnt;   // 1-based count of bus cycles in the current transfer
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic [2:0]  m_op;
  bit          m_core_fin, m_dbg_fin;

  task automatic model_reset();
    m_owner    = 0;
    m_prev     = 2;
    m_gcnt     = 0;
    m_core_fin = 1'b0;
    m_dbg_fin  = 1'b0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    logic creq, fin, tout;
    int   w;
    creq = mem_read_mem | mem_write_mem;
    if (reset) begin
      model_reset();
      check("rst_bus_cyc", bus_cyc, 32'h0);
      check("rst_bus_stb", bus_stb, 32'h0);
      check("rst_bus_we", bus_we, 32'h0);
      check("rst_bus_addr", bus_addr, 32'h0);
      check("rst_bus_wdata", bus_wdata, 32'h0);
      check("rst_bus_op", bus_op, 32'h0);
      check("rst_mem_ack", mem_ack_mem, 32'h0);
      check("rst_dbg_ack", dbg_ack, 32'h0);
      check("rst_dbg_err", dbg_err, 32'h0);
      check("rst_stall", stall_pipl, creq);
    end else begin
      fin  = (m_owner != 0) && (bus_ack || m_gcnt == TO);
      tout = (m_owner != 0) && !bus_ack && m_gcnt == TO;
      m_core_fin = (m_owner == 1) && fin;
      m_dbg_fin  = (m_owner == 2) && fin;
      check("bus_cyc", bus_cyc, m_owner != 0);
      check("bus_stb", bus_stb, m_owner != 0);
      if (m_owner != 0) begin
        check("bus_we", bus_we, m_we);
        check("bus_addr", bus_addr, m_addr);
        check("bus_wdata", bus_wdata, m_wdata);
        check("bus_op", bus_op, m_op);
      end
      check("mem_ack", mem_ack_mem, m_core_fin);
      check("mem_rdata", mem_rdata_mem, (m_owner == 1 && bus_ack) ? bus_rdata : 32'h0);
      check("dbg_ack", dbg_ack, m_dbg_fin);
      check("dbg_err", dbg_err, (m_owner == 2) && tout);
      check("dbg_rdata", dbg_rdata, (m_owner == 2 && bus_ack) ? bus_rdata : 32'h0);
      check("stall", stall_pipl, creq && !m_core_fin);
      // advance across the coming rising edge
      if (m_owner != 0) begin
        if (fin) m_owner = 0;
        else m_gcnt++;
      end else begin
        w = 0;
        if (creq && dbg_req) w = (m_prev == 2) ? 1 : 2;
        else if (creq) w = 1;
        else if (dbg_req) w = 2;
        if (w == 1) begin
          m_we = mem_write_mem; m_addr = mem_addr_mem; m_wdata = mem_wdata_mem; m_op = mem_op_mem;
        end else if (w == 2) begin
          m_we = dbg_we; m_addr = dbg_addr; m_wdata = dbg_wdata; m_op = dbg_op;
        end
        if (w != 0) begin
          m_owner = w;
          m_prev  = w;
          m_gcnt  = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [5:0]  v_stall, v_ack, v_cyc, v_dack;
  logic [17:0] v_ack18;
  logic [31:0] v_rd, v_addr, v_wd;
  logic        v_we, v_flag, v_err;
  logic [5:0]  core_t;
  bit          core_on, dbg_on, got;
  int          got_idx, k;

  task automatic do_reset();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    mem_read_mem = 0; mem_write_mem = 0; mem_addr_mem = 0; mem_wdata_mem = 0; mem_op_mem = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_op = 0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_lit_cyc", bus_cyc, 32'h0);
    check("rst_lit_addr", bus_addr, 32'h0);
    step();
    reset = 1'b0;

    // Core load, slave acks on the 4th bus cycle.
    @(negedge clk);
    slv_mode = 1; slv_lat = 4; slv_data = 32'hCAFEF00D;
    step();
    mem_read_mem = 1'b1; mem_addr_mem = 32'h0000_0100; mem_op_mem = 3'b010;
    v_rd = 32'h0; v_addr = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      v_stall[i] = stall_pipl; v_ack[i] = mem_ack_mem; v_cyc[i] = bus_cyc;
      if (mem_ack_mem) v_rd = mem_rdata_mem;
      if (i == 1) v_addr = bus_addr;
      step();
      if (i == 4) mem_read_mem = 1'b0;
    end
    check("load_stall", v_stall, 6'b001111);
    check("load_ack", v_ack, 6'b010000);
    check("load_cyc", v_cyc, 6'b011110);
    check("load_rdata", v_rd, 32'hCAFEF00D);
    check("load_addr", v_addr, 32'h0000_0100);

    // Simultaneous requests after reset: core, then debug, then core again.
    do_reset();
    @(negedge clk);
    slv_lat = 1;
    core_t = 6'b110011;
    step();
    for (int i = 0; i < 6; i++) begin
      mem_read_mem = core_t[i]; dbg_req = 1'b1; dbg_addr = 32'h0000_0040;
      @(negedge clk);
      v_ack[i] = mem_ack_mem; v_dack[i] = dbg_ack; v_cyc[i] = bus_cyc;
      step();
    end
    mem_read_mem = 1'b0; dbg_req = 1'b0;
    check("tie_mem_ack", v_ack, 6'b100010);
    check("tie_dbg_ack", v_dack, 6'b001000);
    check("tie_cyc", v_cyc, 6'b101010);

    // Debug write, slave never acks: timeout on the 16th bus cycle.
    @(negedge clk);
    slv_lat = 0;
    step();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h2000_0000; dbg_wdata = 32'h1234_5678; dbg_op = 3'b010;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("to_addr", bus_addr, 32'h2000_0000);
        check("to_wdata", bus_wdata, 32'h1234_5678);
        check("to_we", bus_we, 32'h1);
      end
      if (i == 15) check("to_early_ack", dbg_ack, 32'h0);
      if (i == 16) begin
        check("to_ack", dbg_ack, 32'h1);
        check("to_err", dbg_err, 32'h1);
        check("to_rdata", dbg_rdata, 32'h0);
      end
      if (i == 17) check("to_cyc_after", bus_cyc, 32'h0);
      step();
      if (i == 16) begin dbg_req = 1'b0; dbg_we = 1'b0; end
    end

    // Reset in the middle of a core transfer.
    step();
    mem_read_mem = 1'b1; mem_addr_mem = 32'h0000_0300;
    @(negedge clk);
    step();
    @(negedge clk);
    check("mid_cyc_before", bus_cyc, 32'h1);
    step();
    mem_read_mem = 1'b0;
    #1 reset = 1'b1;
    model_reset();
    #1;
    check("mid_cyc_async", bus_cyc, 32'h0);
    check("mid_stb_async", bus_stb, 32'h0);
    check("mid_ack_async", mem_ack_mem, 32'h0);
    #1 reset = 1'b0;
    v_flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v_flag = v_flag | mem_ack_mem | bus_cyc;
    end
    check("mid_no_ack", v_flag, 32'h0);
    slv_lat = 2; slv_data = 32'h0BAD_F00D;
    step();
    mem_read_mem = 1'b1; mem_addr_mem = 32'h0000_0044;
    got = 1'b0; got_idx = -1; v_rd = 32'h0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (mem_ack_mem) begin got = 1'b1; got_idx = i; v_rd = mem_rdata_mem; end
      step();
    end
    mem_read_mem = 1'b0;
    check("post_rst_got", got, 32'h1);
    check("post_rst_idx", got_idx, 32'h2);
    check("post_rst_rdata", v_rd, 32'h0BAD_F00D);

    // Stray slave ack while the bus is idle.
    @(negedge clk);
    slv_idle_ack = 1'b1;
    step();
    v_flag = 1'b0; v_rd = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v_flag = v_flag | mem_ack_mem | dbg_ack | bus_cyc;
      v_rd = v_rd | mem_rdata_mem | dbg_rdata;
    end
    check("idle_ack_none", v_flag, 32'h0);
    check("idle_rdata", v_rd, 32'h0);
    slv_idle_ack = 1'b0; slv_lat = 1;
    step();
    dbg_req = 1'b1; dbg_addr = 32'h0000_0800;
    @(negedge clk);
    v_flag = dbg_ack;
    step();
    @(negedge clk);
    check("idle_then_first", v_flag, 32'h0);
    check("idle_then_ack", dbg_ack, 32'h1);
    step();
    dbg_req = 1'b0;

    // Core store with slave ack exactly on the timeout cycle.
    @(negedge clk);
    slv_lat = TO;
    step();
    mem_write_mem = 1'b1; mem_addr_mem = 32'h0000_1000; mem_wdata_mem = 32'hA5A5_5A5A;
    v_err = 1'b0; v_we = 1'b0; v_wd = 32'h0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      v_ack18[i] = mem_ack_mem;
      v_err = v_err | dbg_err | dbg_ack;
      if (i == 1) begin v_we = bus_we; v_wd = bus_wdata; end
      if (i == 17) v_cyc[0] = bus_cyc;
      step();
      if (i == 16) mem_write_mem = 1'b0;
    end
    check("edge_ack", v_ack18, 32'h0001_0000);
    check("edge_no_err", v_err, 32'h0);
    check("edge_we", v_we, 32'h1);
    check("edge_wdata", v_wd, 32'hA5A5_5A5A);
    check("edge_cyc_after", v_cyc[0], 32'h0);

    // Randomized traffic.
    @(negedge clk);
    slv_mode = 0;
    core_on = 1'b0; dbg_on = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (core_on && (m_core_fin || $urandom_range(0, 31) == 0)) begin
        core_on = 1'b0; mem_read_mem = 1'b0; mem_write_mem = 1'b0;
      end else if (!core_on && $urandom_range(0, 2) == 0) begin
        core_on = 1'b1;
        k = $urandom_range(0, 2);
        mem_read_mem = (k != 1); mem_write_mem = (k != 0);
        mem_addr_mem = $urandom; mem_wdata_mem = $urandom; mem_op_mem = 3'($urandom_range(0, 7));
      end
      if (!core_on) begin
        mem_addr_mem = $urandom; mem_wdata_mem = $urandom; mem_op_mem = 3'($urandom_range(0, 7));
      end
      if (dbg_on && (m_dbg_fin || $urandom_range(0, 31) == 0)) begin
        dbg_on = 1'b0; dbg_req = 1'b0;
      end else if (!dbg_on && $urandom_range(0, 2) == 0) begin
        dbg_on = 1'b1; dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = $urandom; dbg_wdata = $urandom; dbg_op = 3'($urandom_range(0, 7));
      end
      if (!dbg_on) begin
        dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = $urandom; dbg_wdata = $urandom; dbg_op = 3'($urandom_range(0, 7));
      end
      if (c % 1000 == 999) begin
        #1 reset = 1'b1;
        model_reset();
        #1 reset = 1'b0;
      end
    end
    mem_read_mem = 1'b0; mem_write_mem = 1'b0; dbg_req = 1'b0;
    repeat (TO + 4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
